// File: rtl/audiodac_feeder_if.sv
// audiodac_feeder_if
//  Bundles the host-side sample bus and the audiodac FIFO handshake of the
//  audiodac feeder into one interface.
//  slave  : the feeder itself (takes host writes and acks, drives status and offers)
//  master : whatever drives the feeder (host pins plus the audiodac FIFO port)
//  Signals:
//   wr_i, dat_i        host write strobe and 16-bit two's complement sample
//   full_o, ovf_o      local buffer full, sticky dropped-write flag
//   level_o            local buffer occupancy
//   fifo_dat_o/rdy_o   sample offered to audiodac and its valid
//   fifo_ack_i         audiodac took the offered sample
//   fifo_full_i        audiodac FIFO full; blocks new offers
//   sent_cnt_o         delivered-sample count (wrapping)
//   timeout_o          sticky handshake-timeout flag
//   clr_i              clears ovf_o, timeout_o and sent_cnt_o
interface audiodac_feeder_if;
  logic        wr_i;
  logic [15:0] dat_i;
  logic        full_o;
  logic        ovf_o;
  logic [4:0]  level_o;
  logic [15:0] fifo_dat_o;
  logic        fifo_rdy_o;
  logic        fifo_ack_i;
  logic        fifo_full_i;
  logic [15:0] sent_cnt_o;
  logic        timeout_o;
  logic        clr_i;

  modport slave (
    input  wr_i, dat_i, fifo_ack_i, fifo_full_i, clr_i,
    output full_o, ovf_o, level_o, fifo_dat_o, fifo_rdy_o, sent_cnt_o, timeout_o
  );

  modport master (
    output wr_i, dat_i, fifo_ack_i, fifo_full_i, clr_i,
    input  full_o, ovf_o, level_o, fifo_dat_o, fifo_rdy_o, sent_cnt_o, timeout_o
  );
endinterface

// File: rtl/audiodac_feeder.sv
// audiodac_feeder
//  Producer side of the audiodac sample-FIFO handshake. Host samples are stored
//  in a small circular buffer and offered one at a time over rdy/ack through an
//  IDLE -> PRESENT -> RELEASE handshake FSM. Also reports buffer level, a
//  wrapping delivered-word count, a sticky overflow flag and a sticky
//  handshake-timeout flag.
//  Ports:
//   clk_i   single clock, rising edge
//   rst_i   synchronous reset, active-high
//   bus     audiodac_feeder_if.slave (host bus, FIFO handshake, status, clear)
//  Parameters:
//   DEPTH   buffer entries, power of two 2..16
//   TIMEOUT PRESENT cycles without ack before timeout_o sets, 1..65535
module audiodac_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk_i,
  input  logic             rst_i,
  audiodac_feeder_if.slave bus
);

  localparam int          PTR_W     = $clog2(DEPTH);
  localparam logic [4:0]  LVL_FULL  = 5'(DEPTH);
  localparam logic [15:0] WAIT_MAX  = 16'(TIMEOUT);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PRESENT, RELEASE} state_t;

  state_t             state_q, state_d;
  logic signed [15:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]         level_q;
  logic signed [15:0] dat_q;
  logic [15:0]        sent_q;
  logic [15:0]        wait_q;
  logic               ovf_q;
  logic               timeout_q;

  logic full;
  logic push;
  logic drop;
  logic rdy;
  logic load;
  logic pop;
  logic wait_tick;
  logic timeout_set;

  assign full = (level_q == LVL_FULL);

  // A pop in the same cycle frees the slot, so a write against a full buffer
  // is still accepted when the head is being acked.
  assign push = bus.wr_i && (!full || pop);
  assign drop = bus.wr_i && full && !pop;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; fifo_full_i only gates the start of an offer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (level_q != 5'd0 && !bus.fifo_full_i) state_d = PRESENT;
      PRESENT: if (bus.fifo_ack_i)                       state_d = RELEASE;
      RELEASE: if (!bus.fifo_ack_i)                      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; acks outside PRESENT are ignored
  always_comb begin
    rdy       = 1'b0;
    load      = 1'b0;
    pop       = 1'b0;
    wait_tick = 1'b0;
    case (state_q)
      IDLE:    load = (level_q != 5'd0) && !bus.fifo_full_i;
      PRESENT: begin
        rdy       = 1'b1;
        pop       = bus.fifo_ack_i;
        wait_tick = !bus.fifo_ack_i;
      end
      default: ;
    endcase
  end

  // Fires once per offer, on the TIMEOUT-th unacked PRESENT cycle
  assign timeout_set = wait_tick && (wait_q == WAIT_LAST);

  // Sample storage carries no reset; only its pointers and level do
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= bus.dat_i;
  end

  // Buffer bookkeeping, offer register and status
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      dat_q     <= '0;
      sent_q    <= '0;
      wait_q    <= '0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + 5'(push) - 5'(pop);

      // The head stays in the buffer until acked, so it is read here
      // without advancing the read pointer.
      if (load) dat_q <= mem[rd_ptr_q];

      if (load)                               wait_q <= '0;
      else if (wait_tick && wait_q != WAIT_MAX) wait_q <= wait_q + 16'd1;

      // Clear outranks a same-cycle ack, overflow or timeout.
      if (bus.clr_i) begin
        sent_q    <= '0;
        ovf_q     <= 1'b0;
        timeout_q <= 1'b0;
      end else begin
        if (pop)         sent_q    <= sent_q + 16'd1;
        if (drop)        ovf_q     <= 1'b1;
        if (timeout_set) timeout_q <= 1'b1;
      end
    end
  end

  assign bus.full_o     = full;
  assign bus.ovf_o      = ovf_q;
  assign bus.level_o    = level_q;
  assign bus.fifo_dat_o = dat_q;
  assign bus.fifo_rdy_o = rdy;
  assign bus.sent_cnt_o = sent_q;
  assign bus.timeout_o  = timeout_q;

endmodule

// File: tb/tb_audiodac_feeder.sv
// Testbench for audiodac_feeder (DEPTH=4, TIMEOUT=8).
//  Stimulus steps on the falling edge (+2); expected samples are queued when
//  written and a separate monitor pops and compares every rdy&ack handshake.
module tb_audiodac_feeder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  audiodac_feeder_if bus();

  audiodac_feeder #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q [$];
  logic [15:0] mon_exp;

  // Ack source: auto mode answers each offer with a 1-cycle ack, manual mode
  // lets the sequence drive it directly.
  logic ack_mode;
  logic man_ack;
  logic auto_ack = 1'b0;
  assign bus.fifo_ack_i = ack_mode ? man_ack : auto_ack;

  always @(negedge clk) auto_ack <= bus.fifo_rdy_o && !auto_ack;

  // Monitor: sample just before the rising edge where the handshake completes
  always @(negedge clk) begin
    #4;
    if (bus.fifo_rdy_o && bus.fifo_ack_i) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL deliver: got %h, no word expected", bus.fifo_dat_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.fifo_dat_o !== mon_exp) begin
          n_err++;
          $display("FAIL deliver: got %h, want %h", bus.fifo_dat_o, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic write(input logic [15:0] d, input bit keep);
    bus.wr_i  = 1'b1;
    bus.dat_i = d;
    if (keep) exp_q.push_back(d);
    step();
    bus.wr_i = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.fifo_rdy_o) && k < 100) begin
      step();
      k++;
    end
    n_vec++;
    if (k >= 100) begin
      n_err++;
      $display("FAIL drain: %0d words left, want 0", exp_q.size());
    end
    step();
    step();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},     16'(bus.fifo_rdy_o), 16'd0);
    check({tag, "_dat"},     bus.fifo_dat_o,      16'h0000);
    check({tag, "_full"},    16'(bus.full_o),     16'd0);
    check({tag, "_ovf"},     16'(bus.ovf_o),      16'd0);
    check({tag, "_level"},   16'(bus.level_o),    16'd0);
    check({tag, "_sent"},    bus.sent_cnt_o,      16'h0000);
    check({tag, "_timeout"}, 16'(bus.timeout_o),  16'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.wr_i        = 1'b0;
    bus.dat_i       = 16'h0000;
    bus.fifo_full_i = 1'b0;
    bus.clr_i       = 1'b0;
    ack_mode        = 1'b0;
    man_ack         = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check_reset_vals("reset");

    // 1: single word, 1-cycle ack
    write(16'h1234, 1'b1);
    check("t1_level1", 16'(bus.level_o), 16'd1);
    check("t1_rdy_early", 16'(bus.fifo_rdy_o), 16'd0);
    step();
    check("t1_rdy", 16'(bus.fifo_rdy_o), 16'd1);
    check("t1_dat", bus.fifo_dat_o, 16'h1234);
    step();
    check("t1_sent", bus.sent_cnt_o, 16'd1);
    check("t1_level0", 16'(bus.level_o), 16'd0);
    drain();

    // 2: overflow with audiodac FIFO full, then in-order delivery
    bus.fifo_full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      write(16'(16'hA001 + i), i < 4);
      if (i == 3) begin
        check("t2_full_after4", 16'(bus.full_o), 16'd1);
        check("t2_ovf_before5", 16'(bus.ovf_o), 16'd0);
      end
    end
    check("t2_full", 16'(bus.full_o), 16'd1);
    check("t2_ovf", 16'(bus.ovf_o), 16'd1);
    check("t2_level", 16'(bus.level_o), 16'd4);
    check("t2_rdy_blocked", 16'(bus.fifo_rdy_o), 16'd0);
    bus.fifo_full_i = 1'b0;
    drain();
    check("t2_sent", bus.sent_cnt_o, 16'd5);
    check("t2_full_clear", 16'(bus.full_o), 16'd0);
    bus.clr_i = 1'b1;
    step();
    bus.clr_i = 1'b0;
    check("t2_ovf_clr", 16'(bus.ovf_o), 16'd0);
    check("t2_sent_clr", bus.sent_cnt_o, 16'd0);

    // 3: long ack consumes exactly one word
    ack_mode = 1'b1;
    man_ack  = 1'b0;
    write(16'hB001, 1'b1);
    write(16'hB002, 1'b1);
    check("t3_rdy", 16'(bus.fifo_rdy_o), 16'd1);
    check("t3_dat0", bus.fifo_dat_o, 16'hB001);
    man_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_rdy_long_ack", 16'(bus.fifo_rdy_o), 16'd0);
      check("t3_level_long_ack", 16'(bus.level_o), 16'd1);
    end
    man_ack = 1'b0;
    step();
    check("t3_rdy_release", 16'(bus.fifo_rdy_o), 16'd0);
    step();
    check("t3_rdy2", 16'(bus.fifo_rdy_o), 16'd1);
    check("t3_dat1", bus.fifo_dat_o, 16'hB002);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    step();
    check("t3_sent", bus.sent_cnt_o, 16'd2);
    check("t3_level", 16'(bus.level_o), 16'd0);

    // 4: handshake timeout without data loss
    write(16'hC0DE, 1'b1);
    step();
    check("t4_rdy", 16'(bus.fifo_rdy_o), 16'd1);
    repeat (7) step();
    check("t4_timeout_7", 16'(bus.timeout_o), 16'd0);
    step();
    check("t4_timeout_8", 16'(bus.timeout_o), 16'd1);
    check("t4_rdy_held", 16'(bus.fifo_rdy_o), 16'd1);
    check("t4_dat_held", bus.fifo_dat_o, 16'hC0DE);
    repeat (3) step();
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    step();
    check("t4_timeout_sticky", 16'(bus.timeout_o), 16'd1);
    check("t4_sent", bus.sent_cnt_o, 16'd3);
    bus.clr_i = 1'b1;
    step();
    bus.clr_i = 1'b0;
    check("t4_timeout_clr", 16'(bus.timeout_o), 16'd0);

    // 5: count wrap and pointer wrap over 3*DEPTH words
    force dut.sent_q = 16'hFFFF;
    #1;
    release dut.sent_q;
    check("t5_sent_preload", bus.sent_cnt_o, 16'hFFFF);
    ack_mode = 1'b0;
    write(16'h5000, 1'b1);
    drain();
    check("t5_sent_wrap", bus.sent_cnt_o, 16'h0000);
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 4; i++) write(16'(16'h6000 + g * 16 + i), 1'b1);
      drain();
    end
    check("t5_sent12", bus.sent_cnt_o, 16'd12);
    check("t5_level", 16'(bus.level_o), 16'd0);

    // 6: reset mid-offer, then clear against a same-cycle ack
    ack_mode = 1'b1;
    man_ack  = 1'b0;
    write(16'hD001, 1'b1);
    write(16'hD002, 1'b1);
    write(16'hD003, 1'b1);
    check("t6_rdy_pre", 16'(bus.fifo_rdy_o), 16'd1);
    check("t6_level_pre", 16'(bus.level_o), 16'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check_reset_vals("t6_rst");
    write(16'hE001, 1'b1);
    step();
    check("t6_rdy", 16'(bus.fifo_rdy_o), 16'd1);
    man_ack   = 1'b1;
    bus.clr_i = 1'b1;
    step();
    man_ack   = 1'b0;
    bus.clr_i = 1'b0;
    check("t6_clr_beats_ack", bus.sent_cnt_o, 16'd0);
    check("t6_level", 16'(bus.level_o), 16'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
